// File: rtl/gray_pixel_packer_ci.sv
// gray_pixel_packer_ci: packs four pushed gray bytes into 32-bit words and queues them in a FIFO.
// Optional build macro GRAY_PACK_BINARIZE_EN adds threshold binarization and the SETTHR opcode.
`default_nettype none

module gray_pixel_packer_ci #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         FIFO_DEPTH          = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] OP_PUSH   = 3'd0;
  localparam logic [2:0] OP_POP    = 3'd1;
  localparam logic [2:0] OP_STATUS = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;
  localparam logic [2:0] OP_SETTHR = 3'd4;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [2:0]     op_q;
  logic [7:0]     a_q;
  logic [31:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]  count, count_nxt;
  logic [1:0]     byte_cnt, byte_cnt_nxt;
  logic [31:0]    partial, partial_nxt;
  logic           ovf, udf, ovf_nxt, udf_nxt;
  logic           mem_we;
  logic [31:0]    mem_wdata;
  logic [31:0]    res;
  logic [7:0]     pix;
  logic           accept;
  logic           exec;
  logic           unused_bits;

  assign unused_bits = ^{valueA[31:8], valueB[31:3]};

  assign accept = start && (iseId == customInstructionId) && (state == S_IDLE);
  assign exec   = (state == S_EXEC);

  function automatic logic [31:0] status_word(input logic [CW-1:0] cnt, input logic [1:0] bc,
                                              input logic ov, input logic ud);
    logic [7:0] cnt8;
    cnt8 = 8'(cnt);
    return {12'd0, ud, ov, (cnt == CW'(FIFO_DEPTH)), (cnt == '0), 6'd0, bc, cnt8};
  endfunction

`ifdef GRAY_PACK_BINARIZE_EN
  logic [7:0] thr, thr_nxt;
  assign pix = (a_q >= thr) ? 8'hFF : 8'h00;
`else
  assign pix = a_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      op_q  <= 3'd0;
      a_q   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= valueB[2:0];
        a_q  <= valueA[7:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Instruction executes during the done cycle; state commits at the edge ending it.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    byte_cnt_nxt = byte_cnt;
    partial_nxt  = partial;
    ovf_nxt      = ovf;
    udf_nxt      = udf;
    mem_we       = 1'b0;
    mem_wdata    = 32'd0;
    res          = 32'd0;
`ifdef GRAY_PACK_BINARIZE_EN
    thr_nxt      = thr;
`endif
    case (op_q)
      OP_PUSH: begin
        partial_nxt[8*byte_cnt +: 8] = pix;
        byte_cnt_nxt = byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          if (count != CW'(FIFO_DEPTH)) begin
            mem_we     = 1'b1;
            mem_wdata  = partial_nxt;
            wr_ptr_nxt = wr_ptr + 1'b1;
            count_nxt  = count + 1'b1;
          end else begin
            ovf_nxt = 1'b1;
          end
          partial_nxt = 32'd0;
        end
        res = status_word(count_nxt, byte_cnt_nxt, ovf_nxt, udf);
      end
      OP_POP: begin
        if (count != '0) begin
          res        = mem[rd_ptr];
          rd_ptr_nxt = rd_ptr + 1'b1;
          count_nxt  = count - 1'b1;
        end else begin
          udf_nxt = 1'b1;
        end
      end
      OP_STATUS: res = status_word(count, byte_cnt, ovf, udf);
      OP_CLEAR: begin
        wr_ptr_nxt   = '0;
        rd_ptr_nxt   = '0;
        count_nxt    = '0;
        byte_cnt_nxt = 2'd0;
        partial_nxt  = 32'd0;
        ovf_nxt      = 1'b0;
        udf_nxt      = 1'b0;
      end
`ifdef GRAY_PACK_BINARIZE_EN
      OP_SETTHR: begin
        thr_nxt = a_q;
        res     = {24'd0, a_q};
      end
`else
      OP_SETTHR: res = 32'd0;
`endif
      default: res = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      byte_cnt <= 2'd0;
      partial  <= 32'd0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
`ifdef GRAY_PACK_BINARIZE_EN
      thr      <= 8'h80;
`endif
    end else if (exec) begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      byte_cnt <= byte_cnt_nxt;
      partial  <= partial_nxt;
      ovf      <= ovf_nxt;
      udf      <= udf_nxt;
`ifdef GRAY_PACK_BINARIZE_EN
      thr      <= thr_nxt;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset && exec && mem_we) begin
      mem[wr_ptr] <= mem_wdata;
    end
  end

  // Reset held low during the completion cycle cancels the pending pulse.
  assign done   = exec && reset;
  assign result = done ? res : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_gray_pixel_packer_ci.sv
// Directed self-checking bench for gray_pixel_packer_ci (FIFO_DEPTH=16, id 8'd0).
`default_nettype none

module tb_gray_pixel_packer_ci;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  iseId;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  int vectors;
  int miscompares;

  gray_pixel_packer_ci #(.customInstructionId(8'd0), .FIFO_DEPTH(16)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .iseId  (iseId),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issues one instruction; returns done/result one cycle after accept and done one cycle later.
  task automatic exec(input logic [2:0] op, input logic [7:0] a,
                      output logic d1, output logic [31:0] r1, output logic d2);
    start  = 1'b1;
    iseId  = 8'd0;
    valueA = {24'hABCDEF, a};
    valueB = {29'h1234567, op};
    @(posedge clock); #1;
    start = 1'b0;
    d1 = done;
    r1 = result;
    @(posedge clock); #1;
    d2 = done;
  endtask

  task automatic test_reset();
    logic d1, d2;
    logic [31:0] r1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (done !== 1'b0 || result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: done=%b result=%h, want done=0 result=00000000", done, result);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    exec(3'd2, 8'h00, d1, r1, d2);
    vectors++;
    if (d1 !== 1'b1 || d2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done_latency: done=%b then %b, want 1 then 0", d1, d2);
    end
    vectors++;
    if (r1 !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL reset_status: got %h want 00010000", r1);
    end
  endtask

  task automatic test_pack();
    logic d1, d2;
    logic [31:0] r1;
    exec(3'd0, 8'h11, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0001_0100) begin
      miscompares++;
      $display("FAIL pack_first_push_status: got %h want 00010100", r1);
    end
    exec(3'd0, 8'h22, d1, r1, d2);
    exec(3'd0, 8'h33, d1, r1, d2);
    exec(3'd0, 8'h44, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL pack_fourth_push_status: got %h want 00000001", r1);
    end
    exec(3'd1, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h4433_2211) begin
      miscompares++;
      $display("FAIL pack_pop: got %h want 44332211", r1);
    end
    exec(3'd2, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL pack_status_after_pop: got %h want 00010000", r1);
    end
  endtask

  task automatic test_full_overflow();
    logic d1, d2;
    logic [31:0] r1;
    logic [31:0] exp;
    for (int i = 0; i < 64; i++) exec(3'd0, 8'(i), d1, r1, d2);
    exec(3'd2, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0002_0010) begin
      miscompares++;
      $display("FAIL full_status: got %h want 00020010", r1);
    end
    exec(3'd0, 8'hE0, d1, r1, d2);
    exec(3'd0, 8'hE1, d1, r1, d2);
    exec(3'd0, 8'hE2, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0002_0310) begin
      miscompares++;
      $display("FAIL full_partial_lanes: got %h want 00020310", r1);
    end
    exec(3'd0, 8'hE3, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0006_0010) begin
      miscompares++;
      $display("FAIL overflow_status: got %h want 00060010", r1);
    end
    exec(3'd1, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0302_0100) begin
      miscompares++;
      $display("FAIL full_first_pop: got %h want 03020100", r1);
    end
    // Freed slot takes a new word; write pointer wraps into slot 0.
    exec(3'd0, 8'hAA, d1, r1, d2);
    exec(3'd0, 8'hBB, d1, r1, d2);
    exec(3'd0, 8'hCC, d1, r1, d2);
    exec(3'd0, 8'hDD, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0006_0010) begin
      miscompares++;
      $display("FAIL reuse_push_status: got %h want 00060010", r1);
    end
    for (int k = 1; k < 16; k++) begin
      exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      exec(3'd1, 8'h00, d1, r1, d2);
      vectors++;
      if (r1 !== exp) begin
        miscompares++;
        $display("FAIL drain_pop_%0d: got %h want %h", k, r1, exp);
      end
    end
    exec(3'd1, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'hDDCC_BBAA) begin
      miscompares++;
      $display("FAIL reuse_pop: got %h want DDCCBBAA", r1);
    end
    exec(3'd2, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0005_0000) begin
      miscompares++;
      $display("FAIL drained_status: got %h want 00050000", r1);
    end
  endtask

  task automatic test_underflow_clear();
    logic d1, d2;
    logic [31:0] r1;
    exec(3'd3, 8'h00, d1, r1, d2);
    vectors++;
    if (d1 !== 1'b1 || r1 !== 32'd0) begin
      miscompares++;
      $display("FAIL clear_result: done=%b result=%h want 1/00000000", d1, r1);
    end
    exec(3'd1, 8'h00, d1, r1, d2);
    vectors++;
    if (d1 !== 1'b1 || r1 !== 32'd0) begin
      miscompares++;
      $display("FAIL empty_pop: done=%b result=%h want 1/00000000", d1, r1);
    end
    exec(3'd2, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0009_0000) begin
      miscompares++;
      $display("FAIL underflow_status: got %h want 00090000", r1);
    end
    exec(3'd3, 8'h00, d1, r1, d2);
    exec(3'd2, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL clear_status: got %h want 00010000", r1);
    end
  endtask

  task automatic test_foreign_id();
    logic d1, d2;
    logic [31:0] r1;
    logic fd1, fd2;
    logic [31:0] fr1, fr2;
    start  = 1'b1;
    iseId  = 8'h05;
    valueA = 32'h0000_0077;
    valueB = 32'd0;
    @(posedge clock); #1;
    start = 1'b0;
    fd1 = done;
    fr1 = result;
    @(posedge clock); #1;
    fd2 = done;
    fr2 = result;
    iseId = 8'd0;
    vectors++;
    if (fd1 !== 1'b0 || fd2 !== 1'b0 || fr1 !== 32'd0 || fr2 !== 32'd0) begin
      miscompares++;
      $display("FAIL foreign_id_outputs: done=%b%b result=%h/%h want 00 and zero", fd1, fd2, fr1, fr2);
    end
    exec(3'd2, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL foreign_id_state: got %h want 00010000", r1);
    end
  endtask

  task automatic test_noop();
    logic d1, d2;
    logic [31:0] r1;
    exec(3'd0, 8'h5A, d1, r1, d2);
    for (int op = 5; op < 8; op++) begin
      exec(3'(op), 8'hFF, d1, r1, d2);
      vectors++;
      if (d1 !== 1'b1 || d2 !== 1'b0 || r1 !== 32'd0) begin
        miscompares++;
        $display("FAIL noop_op%0d: done=%b%b result=%h want 10/00000000", op, d1, d2, r1);
      end
    end
    exec(3'd2, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0001_0100) begin
      miscompares++;
      $display("FAIL noop_state: got %h want 00010100", r1);
    end
    exec(3'd3, 8'h00, d1, r1, d2);
  endtask

  task automatic test_binarize();
    logic d1, d2;
    logic [31:0] r1;
    logic [31:0] exp_thr;
    logic [31:0] exp_word;
`ifdef GRAY_PACK_BINARIZE_EN
    exp_thr  = 32'h0000_0040;
    exp_word = 32'h00FF_FF00;
`else
    exp_thr  = 32'h0000_0000;
    exp_word = 32'h00FF_403F;
`endif
    exec(3'd4, 8'h40, d1, r1, d2);
    vectors++;
    if (d1 !== 1'b1 || r1 !== exp_thr) begin
      miscompares++;
      $display("FAIL setthr: done=%b result=%h want 1/%h", d1, r1, exp_thr);
    end
    exec(3'd0, 8'h3F, d1, r1, d2);
    exec(3'd0, 8'h40, d1, r1, d2);
    exec(3'd0, 8'hFF, d1, r1, d2);
    exec(3'd0, 8'h00, d1, r1, d2);
    exec(3'd1, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== exp_word) begin
      miscompares++;
      $display("FAIL binarize_pop: got %h want %h", r1, exp_word);
    end
  endtask

  task automatic test_reset_pending();
    logic d1, d2;
    logic [31:0] r1;
    for (int i = 0; i < 5; i++) exec(3'd0, 8'(8'h90 + i), d1, r1, d2);
    start  = 1'b1;
    iseId  = 8'd0;
    valueA = 32'h0000_0066;
    valueB = 32'd0;
    @(posedge clock);
    start = 1'b0;
    reset = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b0 || result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cancels_done: done=%b result=%h want 0/00000000", done, result);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    exec(3'd2, 8'h00, d1, r1, d2);
    vectors++;
    if (r1 !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL reset_pending_status: got %h want 00010000", r1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b0;
    start  = 1'b0;
    iseId  = 8'd0;
    valueA = 32'd0;
    valueB = 32'd0;
    test_reset();
    test_pack();
    test_full_overflow();
    test_underflow_clear();
    test_foreign_id();
    test_noop();
    test_binarize();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gray_pixel_packer_ci.md
Name: gray_pixel_packer_ci

Overview:
- Custom-instruction block directly downstream of the RGB565-to-grayscale instruction.
- Software pushes the 8-bit gray results one at a time. The block packs four consecutive bytes into one 32-bit word and queues it in an internal FIFO.
- Software pops packed words for burst-writing to the grayscale frame buffer. This cuts memory stores by 4x.
- Shares the CPU custom-instruction bus (start/iseId/valueA/valueB/done/result) with the other ISEs.

Parameters:
- customInstructionId, 8'd0, iseId value this block responds to.
- FIFO_DEPTH, 16, packed-word FIFO entries; power of two, 2..128.

Ports:
- clock  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-low reset: sampled on rising clock edge, reset while 0.
- start  input  1  single-cycle instruction strobe.
- iseId  input  8  custom-instruction selector; block acts only when equal to customInstructionId.
- valueA  input  32  operand A; push uses [7:0] as gray byte; set-threshold uses [7:0].
- valueB  input  32  operand B; [2:0] opcode, [31:3] ignored.
- done  output  1  one-cycle completion pulse.
- result  output  32  instruction result, valid only while done=1, else 32'd0.

Behaviour:
- Accept condition: start=1 and iseId==customInstructionId. Operands and opcode are registered on accept.
- Every opcode has fixed latency 1: done=1 exactly on the cycle after accept, for one cycle.
- The CPU stalls until done, so no new accept can arrive while done is pending.
- Reset (reset=0 at a clock edge):
  - done=0, result=0, FIFO empty, read/write pointers=0, byteCount=0, partial word=0, all flags=0, threshold=8'h80.
  - A pending done is cancelled.
- Opcodes (valueB[2:0]):
  - 0 PUSH: write valueA[7:0] into lane byteCount of the partial word (lane 0 = bits 7:0, first pixel). Then byteCount increments.
    - On the 4th byte (byteCount 3->0 wrap): if FIFO not full, write the completed word at wrPtr and advance wrPtr.
    - If FIFO is full, drop the word and set sticky overflow.
    - byteCount wraps to 0 in both cases.
    - result = STATUS word after the update.
  - 1 POP: if FIFO not empty, result = word at rdPtr and rdPtr advances. If empty, result = 32'd0 and sticky underflow is set.
  - 2 STATUS: result = STATUS word; no state change.
  - 3 CLEAR: pointers, count, byteCount, partial word and flags go to 0; threshold is kept. result = 32'd0.
  - 4 SETTHR: see Optional Feature.
  - 5..7: no-op, result = 32'd0, done still pulses.
- STATUS word:
  - [7:0] FIFO word count (0..FIFO_DEPTH)
  - [9:8] byteCount
  - [16] empty
  - [17] full
  - [18] overflow
  - [19] underflow
  - all other bits 0.
- FIFO: pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is held separately so full and empty are unambiguous.
- Boundary cases:
  - Full FIFO with partial bytes pending: PUSH still fills lanes 0..2 normally. Only the completing push drops.
  - POP of the last word sets empty in the same update.
  - A popped slot is immediately reusable.
- Sticky flags clear only on CLEAR or reset.

Optional Feature:
- Macro GRAY_PACK_BINARIZE_EN.
- Defined:
  - PUSH stores 8'hFF if valueA[7:0] >= threshold, else 8'h00.
  - SETTHR loads threshold <= valueA[7:0] and returns {24'd0, new threshold}.
- Undefined:
  - Bytes are stored unmodified.
  - SETTHR is a no-op returning 32'd0.
  - No threshold register is synthesized.

Test Plan:
- Reset, then STATUS -> done one cycle after start; result=32'h0001_0000 (empty=1, count=0, byteCount=0).
- PUSH 8'h11, 8'h22, 8'h33, 8'h44, then POP -> POP result=32'h4433_2211; next STATUS result=32'h0001_0000.
- PUSH 4*FIFO_DEPTH bytes (16 words) -> STATUS result=32'h0002_0010 (full). Four more PUSHes -> overflow set, result=32'h0006_0010. First POP returns the first packed word.
- POP on empty FIFO -> result=32'd0, then STATUS=32'h0009_0000 (empty + underflow). CLEAR -> STATUS=32'h0001_0000.
- start=1 with iseId != customInstructionId, any opcode -> done stays 0, result stays 0, state unchanged.
- With GRAY_PACK_BINARIZE_EN defined: SETTHR 8'h40 returns 32'h0000_0040. Then PUSH 8'h3F, 8'h40, 8'hFF, 8'h00 and POP -> 32'h00FF_FF00.
- Drive reset=0 on the cycle after a PUSH accept -> done=0 that cycle; afterwards STATUS=32'h0001_0000.
